expr_gen: RTL and testbench

EXPR_GEN -- requirements
Module: expr_gen

---
 rtl/expr_gen.sv | 172 +++++++++++++++++
 tb/tb_expr_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/expr_gen.sv
// ---------------------------------------------------------------------------
// expr_gen -- streams an arithmetic expression as ASCII characters.
//
// A request captures up to four 8-bit unsigned terms and the operators
// between them, then emits the expression one character per handshake,
// e.g. "12+0*255". Each term is printed in decimal, most significant digit
// first, with leading zeros suppressed.
//
// Ports:
//   clk        rising-edge clock
//   clr_n      synchronous active-low clear
//   start      request strobe, only honoured in IDLE
//   num_terms  number of terms minus one
//   operands   term i in bits [8i+7:8i], term 0 emitted first
//   ops        bit i: operator after term i (0 = '+', 1 = '*')
//   out_ready  sink accepts out_data this cycle
//   out_valid  out_data carries a character
//   out_data   ASCII character
//   out_last   final character of the expression
//   busy       expression in progress
//   done       one-cycle completion pulse
//
// Build option:
//   EXPR_GEN_TERM_EN  when defined, an '=' terminator follows the final
//                     term and carries out_last.
//
// state | meaning
// IDLE  | waiting for start
// DIGIT | emitting a digit of term term_idx
// OPER  | emitting the operator after term term_idx (or '=' after the last)
// FIN   | one-cycle done pulse, start ignored
// ---------------------------------------------------------------------------
module expr_gen (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [1:0]  num_terms,
    input  logic [31:0] operands,
    input  logic [2:0]  ops,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, DIGIT, OPER, FIN} state_t;

    state_t      state, state_nx;
    logic [1:0]  nt_r;
    logic [31:0] operands_r;
    logic [2:0]  ops_r;
    logic [1:0]  term_idx;
    logic [1:0]  dig_pos;      // 2 = hundreds, 1 = tens, 0 = ones
    logic [1:0]  term_nx;
    logic [7:0]  cur_val;
    logic [7:0]  nxt_val;
    logic [3:0]  ops_ext;
    logic        final_term;
    logic        xfer;

    // Position of the most significant non-zero digit; 0 prints as "0".
    function automatic logic [1:0] top_pos(input logic [7:0] v);
        if (v >= 8'd100)
            return 2'd2;
        else if (v >= 8'd10)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    function automatic logic [3:0] digit_at(input logic [7:0] v, input logic [1:0] pos);
        logic [7:0] d;
        case (pos)
            2'd2:    d = v / 8'd100;
            2'd1:    d = (v / 8'd10) % 8'd10;
            default: d = v % 8'd10;
        endcase
        return d[3:0];
    endfunction

    assign term_nx    = term_idx + 2'd1;
    assign cur_val    = operands_r[{term_idx, 3'b000} +: 8];
    assign nxt_val    = operands_r[{term_nx, 3'b000} +: 8];
    assign ops_ext    = {1'b0, ops_r};
    assign final_term = (term_idx == nt_r);
    assign xfer       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state      <= IDLE;
            nt_r       <= 2'd0;
            operands_r <= 32'd0;
            ops_r      <= 3'd0;
            term_idx   <= 2'd0;
            dig_pos    <= 2'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        nt_r       <= num_terms;
                        operands_r <= operands;
                        ops_r      <= ops;
                        term_idx   <= 2'd0;
                        dig_pos    <= top_pos(operands[7:0]);
                    end
                end
                DIGIT: begin
                    if (xfer && dig_pos != 2'd0)
                        dig_pos <= dig_pos - 2'd1;
                end
                OPER: begin
                    if (xfer && !final_term) begin
                        term_idx <= term_nx;
                        dig_pos  <= top_pos(nxt_val);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = DIGIT;
            end
            DIGIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = 8'h30 | {4'h0, digit_at(cur_val, dig_pos)};
`ifdef EXPR_GEN_TERM_EN
                // The terminator always follows the last digit of the final term.
                if (xfer && dig_pos == 2'd0)
                    state_nx = OPER;
`else
                out_last = final_term && (dig_pos == 2'd0);
                if (xfer && dig_pos == 2'd0)
                    state_nx = final_term ? FIN : OPER;
`endif
            end
            OPER: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                // OPER on the final term only occurs with the terminator enabled.
                if (final_term) begin
                    out_data = 8'h3D;
                    out_last = 1'b1;
                end else begin
                    out_data = ops_ext[term_idx] ? 8'h2A : 8'h2B;
                end
                if (xfer)
                    state_nx = final_term ? FIN : DIGIT;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_expr_gen.sv
module tb_expr_gen;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [1:0]  num_terms;
    logic [31:0] operands;
    logic [2:0]  ops;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int tests  = 0;
    int failed = 0;

    logic [8:0] sb[$];   // {last, char}

    expr_gen dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .num_terms (num_terms),
        .operands  (operands),
        .ops       (ops),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference text of the expression, pushed when the request is driven.
    task automatic push_expected(input logic [1:0] nt, input logic [31:0] opnd, input logic [2:0] op);
        logic [8:0] tail;
        int v;
        for (int i = 0; i <= int'(nt); i++) begin
            v = int'(opnd[8*i +: 8]);
            if (v >= 100) sb.push_back({1'b0, 8'(8'd48 + v / 100)});
            if (v >= 10)  sb.push_back({1'b0, 8'(8'd48 + (v / 10) % 10)});
            sb.push_back({1'b0, 8'(8'd48 + v % 10)});
            if (i < int'(nt)) sb.push_back({1'b0, op[i] ? 8'h2A : 8'h2B});
        end
`ifdef EXPR_GEN_TERM_EN
        sb.push_back({1'b0, 8'h3D});
`endif
        tail = sb.pop_back();
        tail[8] = 1'b1;
        sb.push_back(tail);
    endtask

    task automatic run_expr(input logic [1:0] nt, input logic [31:0] opnd, input logic [2:0] op,
                            input int stall_idx, input int stall_n, input int busy_start_idx,
                            input int abort_idx, input bit fin_start);
        int idx = 0;
        int cyc = 0;
        int stall_cnt = 0;
        bit aborted = 0;
        logic [8:0] exp;

        push_expected(nt, opnd, op);
        num_terms = nt;
        operands  = opnd;
        ops       = op;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        // captured copies must be used from here on
        num_terms = ~nt;
        operands  = ~opnd;
        ops       = ~op;
        check("first_valid", 32'(out_valid), 32'd1);
        check("busy_after_start", 32'(busy), 32'd1);

        while (sb.size() > 0 && cyc < 200) begin
            if (idx == abort_idx) begin
                clr_n     = 1'b0;
                out_ready = 1'b1;
                start     = 1'b1;
                @(negedge clk);
                check("clr_valid", 32'(out_valid), 32'd0);
                check("clr_busy", 32'(busy), 32'd0);
                check("clr_data", 32'(out_data), 32'd0);
                check("clr_last", 32'(out_last), 32'd0);
                clr_n   = 1'b1;
                start   = 1'b0;
                sb.delete();
                aborted = 1;
                break;
            end
            start     = (idx == busy_start_idx);
            out_ready = !(idx == stall_idx && stall_cnt < stall_n);
            if (out_valid) begin
                check("done_low_mid", 32'(done), 32'd0);
                if (out_ready) begin
                    exp = sb.pop_front();
                    check("char", 32'(out_data), 32'(exp[7:0]));
                    check("last", 32'(out_last), 32'(exp[8]));
                    idx++;
                end else begin
                    check("stall_hold", 32'({out_last, out_data}), 32'(sb[0]));
                    stall_cnt++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 200) begin
            check("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        if (!aborted) begin
            check("fin_done", 32'(done), 32'd1);
            check("fin_busy", 32'(busy), 32'd0);
            check("fin_valid", 32'(out_valid), 32'd0);
            start = fin_start;
            @(negedge clk);
            start = 1'b0;
            check("idle_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        clr_n     = 1'b0;
        start     = 1'b1;
        num_terms = 2'd0;
        operands  = 32'd0;
        ops       = 3'd0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        clr_n = 1'b1;
        start = 1'b0;
        @(negedge clk);

        // single digit term
        run_expr(2'd0, 32'h0000_0007, 3'b000, -1, 0, -1, -1, 0);
        run_expr(2'd0, 32'h0000_0005, 3'b000, -1, 0, -1, -1, 0);
        // "12+0*255", stall on '+', start while busy, start during FIN
        run_expr(2'd2, {8'd0, 8'd255, 8'd0, 8'd12}, 3'b010, 2, 3, 4, -1, 1);
        // "100*9*10*1"
        run_expr(2'd3, {8'd1, 8'd10, 8'd9, 8'd100}, 3'b111, -1, 0, -1, -1, 0);
        // clear mid-stream, then a fresh expression from term 0
        run_expr(2'd3, {8'd200, 8'd77, 8'd6, 8'd150}, 3'b101, -1, 0, -1, 3, 0);
        @(negedge clk);
        run_expr(2'd1, {8'd0, 8'd0, 8'd45, 8'd3}, 3'b001, 1, 2, -1, -1, 0);
        // leading zeros suppressed, zero term prints "0"
        run_expr(2'd3, {8'd0, 8'd99, 8'd10, 8'd249}, 3'b100, 5, 1, -1, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
